// File: rtl/dac_spi_pkg.sv
// ============================================================================
// Module : dac_spi_pkg
// Brief  : Frame layout, command codes and receiver state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dac_spi_pkg;

  localparam int FRAME_BITS = 24;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

  localparam logic [3:0] CMD_NOP          = 4'h0;
  localparam logic [3:0] CMD_WRITE_IN     = 4'h1;
  localparam logic [3:0] CMD_UPDATE       = 4'h2;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;

  localparam logic [3:0] CH_DDS = 4'h1;
  localparam logic [3:0] CH_CW  = 4'h8;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t ST_WAIT_IDLE = 2'd0;
  localparam rx_state_t ST_IDLE      = 2'd1;
  localparam rx_state_t ST_SHIFT     = 2'd2;
  localparam rx_state_t ST_DECODE    = 2'd3;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [15:0] data;
  } frame_t;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd <= CMD_WRITE_UPDATE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dac_spi_responder_spi_frame_rx.sv
// ============================================================================
// Module : spi_frame_rx
// Brief  : Input synchronizers, edge detection and 24-bit frame capture FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_frame_rx
  import dac_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_ss_n,
  input  logic                  i_sck,
  input  logic                  i_mosi,
  input  logic                  i_ldac_n,
  output logic                  o_frame_done,
  output logic                  o_frame_start,
  output logic                  o_sck_rise,
  output logic                  o_ldac_fall,
  output logic [CNT_W-1:0]      o_bit_count,
  output logic [FRAME_BITS-1:0] o_frame
);

  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ldac_sync;
  logic                   r_ss_q;
  logic                   r_sck_q;
  logic                   r_ldac_q;
  rx_state_t              r_state;
  logic [FRAME_BITS-1:0]  r_sr;
  logic [CNT_W-1:0]       r_cnt;

  logic w_ss;
  logic w_sck;
  logic w_mosi;
  logic w_ldac;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_sck_fall;

  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_ldac = r_ldac_sync[SYNC_STAGES-1];

  assign w_ss_fall  = ~w_ss & r_ss_q;
  assign w_ss_rise  = w_ss & ~r_ss_q;
  assign w_sck_fall = ~w_sck & r_sck_q;

  // ss_n resets low so WAIT_IDLE only leaves once a genuine high has propagated
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ss_sync   <= '0;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_ldac_sync <= '1;
      r_ss_q      <= 1'b0;
      r_sck_q     <= 1'b0;
      r_ldac_q    <= 1'b1;
      r_state     <= ST_WAIT_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ldac_sync <= {r_ldac_sync[SYNC_STAGES-2:0], i_ldac_n};
      r_ss_q      <= w_ss;
      r_sck_q     <= w_sck;
      r_ldac_q    <= w_ldac;

      case (r_state)
        ST_WAIT_IDLE: begin
          if (w_ss) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_state <= ST_SHIFT;
            r_sr    <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_sck_fall) begin
            r_sr <= {r_sr[FRAME_BITS-2:0], w_mosi};
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 5'd1;
          end
          if (w_ss_rise) r_state <= ST_DECODE;
        end
        ST_DECODE: r_state <= ST_IDLE;
        default:   r_state <= ST_WAIT_IDLE;
      endcase
    end
  end

  assign o_frame_done  = (r_state == ST_DECODE);
  assign o_frame_start = (r_state == ST_IDLE) && w_ss_fall;
  assign o_sck_rise    = w_sck & ~r_sck_q;
  assign o_ldac_fall   = ~w_ldac & r_ldac_q;
  assign o_bit_count   = r_cnt;
  assign o_frame       = r_sr;

endmodule

`default_nettype wire

// File: rtl/dac_spi_responder.sv
// ============================================================================
// Module : dac_spi_responder
// Brief  : Quad gain-DAC SPI slave: frame decode, input/DAC registers, LDAC.
//          Readback on spi_miso is built when DAC_RESP_READBACK_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dac_spi_responder
  import dac_spi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RESET_CODE  = 16'h0000,
  parameter int          NUM_CH      = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_spi_ss_n,
  input  logic                   i_spi_sck,
  input  logic                   i_spi_mosi,
  output logic                   o_spi_miso,
  input  logic                   i_ldac_n,
  output logic [16*NUM_CH-1:0]   o_dac_code,
  output logic [NUM_CH-1:0]      o_dac_update,
  output logic                   o_frame_valid,
  output logic                   o_frame_err,
  output logic                   o_cmd_err,
  output logic [FRAME_BITS-1:0]  o_last_frame
);

  logic                  w_done;
  logic                  w_frame_start;
  logic                  w_sck_rise;
  logic                  w_ldac_fall;
  logic [CNT_W-1:0]      w_count;
  logic [FRAME_BITS-1:0] w_rx_data;

  spi_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk           (clk),
    .rstn          (rstn),
    .i_ss_n        (i_spi_ss_n),
    .i_sck         (i_spi_sck),
    .i_mosi        (i_spi_mosi),
    .i_ldac_n      (i_ldac_n),
    .o_frame_done  (w_done),
    .o_frame_start (w_frame_start),
    .o_sck_rise    (w_sck_rise),
    .o_ldac_fall   (w_ldac_fall),
    .o_bit_count   (w_count),
    .o_frame       (w_rx_data)
  );

  logic [15:0]           r_in  [NUM_CH];
  logic [15:0]           r_dac [NUM_CH];
  logic [NUM_CH-1:0]     r_dac_update;
  logic                  r_frame_valid;
  logic                  r_frame_err;
  logic                  r_cmd_err;
  logic [FRAME_BITS-1:0] r_last_frame;

  frame_t                w_frame;
  logic                  w_accept;
  logic                  w_cmd_ok;
  logic [15:0]           w_in_next  [NUM_CH];
  logic [15:0]           w_dac_next [NUM_CH];
  logic [NUM_CH-1:0]     w_upd;

  assign w_frame  = frame_t'(w_rx_data);
  assign w_accept = w_done && (w_count == CNT_W'(FRAME_BITS));
  assign w_cmd_ok = cmd_supported(w_frame.cmd);

  // LDAC is applied after the frame write so a coincident edge loads the new input value
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_in_next[ch]  = r_in[ch];
      w_dac_next[ch] = r_dac[ch];
      w_upd[ch]      = 1'b0;
      if (w_accept && w_cmd_ok && w_frame.addr[ch]) begin
        case (w_frame.cmd)
          CMD_WRITE_IN: begin
            w_in_next[ch] = w_frame.data;
          end
          CMD_UPDATE: begin
            w_dac_next[ch] = r_in[ch];
            w_upd[ch]      = 1'b1;
          end
          CMD_WRITE_UPDATE: begin
            w_in_next[ch]  = w_frame.data;
            w_dac_next[ch] = w_frame.data;
            w_upd[ch]      = 1'b1;
          end
          default: ;
        endcase
      end
      if (w_ldac_fall) begin
        w_dac_next[ch] = w_in_next[ch];
        w_upd[ch]      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_in[ch]  <= RESET_CODE;
        r_dac[ch] <= RESET_CODE;
      end
      r_dac_update  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_last_frame  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_in[ch]  <= w_in_next[ch];
        r_dac[ch] <= w_dac_next[ch];
      end
      r_dac_update  <= w_upd;
      r_frame_valid <= w_accept;
      r_frame_err   <= w_done && !w_accept;
      r_cmd_err     <= w_accept && !w_cmd_ok;
      if (w_accept) r_last_frame <= w_rx_data;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign o_dac_code[16*g +: 16] = r_dac[g];
  end

  assign o_dac_update  = r_dac_update;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_cmd_err     = r_cmd_err;
  assign o_last_frame  = r_last_frame;

`ifdef DAC_RESP_READBACK_EN
  logic [FRAME_BITS-1:0] r_tx;

  // first sck rise of a frame keeps bit 23 so the master's first fall sample sees it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx <= '0;
    end else if (w_frame_start) begin
      r_tx <= r_last_frame;
    end else if (w_done) begin
      r_tx <= '0;
    end else if (w_sck_rise && (w_count != '0)) begin
      r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign o_spi_miso = r_tx[FRAME_BITS-1];
`else
  logic w_unused_rb;
  assign w_unused_rb = &{1'b0, w_frame_start, w_sck_rise};
  assign o_spi_miso  = 1'b0;
`endif

endmodule

`default_nettype wire
